dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port: it accepts the core's write enable, address, store data and access size, and returns load data in the same cycle. Backing storage is a word-organised RAM with sub-word store merge and load extension. The block also provides a small memory-mapped status window and a post-reset clear engine. It sits outside `core_top`, directly on the MEM-stage data port.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory port between the core MEM stage and dmem_responder.
// The core drives the request side; the responder returns load data and status.
interface dmem_responder_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  WriteEn;
    logic [DATA_WIDTH-1:0] MemAddress;
    logic [DATA_WIDTH-1:0] MemStoreData;
    logic [2:0]            Funct3;
    logic [DATA_WIDTH-1:0] MemLoadData;
    logic                  Busy;
    logic                  MisalignErr;
    logic                  AccessErr;

    modport master (
        output WriteEn, MemAddress, MemStoreData, Funct3,
        input  MemLoadData, Busy, MisalignErr, AccessErr
    );

    modport slave (
        input  WriteEn, MemAddress, MemStoreData, Funct3,
        output MemLoadData, Busy, MisalignErr, AccessErr
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with sub-word merge/extension, status window
// and a post-reset clear engine.
//   state    | meaning
//   ST_CLEAR | zeroing one RAM word per cycle, Busy=1, stores dropped
//   ST_READY | normal operation until the next reset
module dmem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned W  = DATA_WIDTH;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          busy;

    logic [W-1:0] mem [DEPTH_WORDS];
    logic [W-1:0] cycle_cnt_q, store_cnt_q, scratch_q;
    logic         misalign_q, access_err_q;
    logic         misalign_d, access_err_d;

    logic         we;
    logic [W-1:0] addr, sdata;
    logic [2:0]   f3;

    logic [AW-1:0] word_idx;
    logic          in_ram, in_mmio, f3_valid, is_half, is_word, misalign;
    logic [W-1:0]  rd_word, ram_load, mmio_load, merged;
    logic [15:0]   lane;
    logic          ram_we, scratch_we;

    assign we    = bus.WriteEn;
    assign addr  = bus.MemAddress;
    assign sdata = bus.MemStoreData;
    assign f3    = bus.Funct3;

    assign word_idx = addr[AW+1:2];
    assign in_ram   = (addr[W-1:AW+2] == '0);
    assign in_mmio  = (addr[W-1:4] == MMIO_BASE[W-1:4]);

    // Invalid size codes share the misalign path; the status window is word-only.
    assign f3_valid = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
    assign is_half  = (f3[1:0] == 2'b01);
    assign is_word  = (f3 == 3'b010);
    assign misalign = !f3_valid || (is_half && addr[0]) ||
                      (is_word && (addr[1:0] != 2'b00)) || (in_mmio && !is_word);

    assign rd_word = mem[word_idx];
    assign lane    = 16'(rd_word >> {addr[1:0], 3'b000});

    always_comb begin
        case (f3)
            3'b000:  ram_load = {{(W-8){lane[7]}}, lane[7:0]};
            3'b001:  ram_load = {{(W-16){lane[15]}}, lane[15:0]};
            3'b100:  ram_load = {{(W-8){1'b0}}, lane[7:0]};
            3'b101:  ram_load = {{(W-16){1'b0}}, lane[15:0]};
            default: ram_load = rd_word;
        endcase
    end

    always_comb begin
        case (addr[3:2])
            2'b00:   mmio_load = cycle_cnt_q;
            2'b01:   mmio_load = store_cnt_q;
            2'b10:   mmio_load = scratch_q;
            default: mmio_load = '0;
        endcase
    end

    assign bus.MemLoadData = (busy || misalign) ? '0 :
                             in_ram             ? ram_load :
                             in_mmio            ? mmio_load : '0;

    always_comb begin
        merged = rd_word;
        case (f3[1:0])
            2'b00:   merged[{addr[1:0], 3'b000} +: 8]  = sdata[7:0];
            2'b01:   merged[{addr[1], 4'b0000} +: 16] = sdata[15:0];
            default: merged = sdata;
        endcase
    end

    assign ram_we       = we && !busy && !misalign && in_ram;
    assign scratch_we   = we && !busy && !misalign && in_mmio && (addr[3:2] == 2'b10);
    assign misalign_d   = !busy && misalign;
    assign access_err_d = !busy && we && !misalign && !in_ram && !in_mmio;

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_idx_q] <= '0;
        end else if (ram_we) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q  <= '0;
            store_cnt_q  <= '0;
            scratch_q    <= '0;
            misalign_q   <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_q + W'(1);
            if (ram_we) begin
                store_cnt_q <= store_cnt_q + W'(1);
            end
            if (scratch_we) begin
                scratch_q <= sdata;
            end
            misalign_q   <= misalign_d;
            access_err_q <= access_err_d;
        end
    end

    assign bus.Busy        = busy;
    assign bus.MisalignErr = misalign_q;
    assign bus.AccessErr   = access_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts
// each cycle's load data, Busy and the error pulses of the previous request.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] MBASE = 32'hFFFF_0000;
    localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_WIDTH(32)) bus ();

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .MMIO_BASE(MBASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] ld;
        bit          busy;
        bit          mis;
        bit          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;
    logic [7:0]  m_bytes [4*DEPTH];
    logic [31:0] m_store_cnt, m_scratch;
    bit          prev_mis, prev_acc;

    // Rising edges seen since reset release: drives CYCLE_CNT and Busy predictions.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4*DEPTH; i++) m_bytes[i] = 8'h00;
        m_store_cnt = 0;
        m_scratch   = 0;
        prev_mis    = 1'b0;
        prev_acc    = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f3, output logic [31:0] ld,
                              output bit mis, output bit acc);
        int          n;
        bit          sgn, valid, busy, ram, mmio;
        logic [31:0] v, off;
        valid = 1'b1; n = 4; sgn = 1'b0;
        case (f3)
            F_B:     begin n = 1; sgn = 1'b1; end
            F_H:     begin n = 2; sgn = 1'b1; end
            F_W:     n = 4;
            F_BU:    n = 1;
            F_HU:    n = 2;
            default: valid = 1'b0;
        endcase
        busy = (cyc < DEPTH);
        ram  = (a < 4*DEPTH);
        off  = a - MBASE;
        mmio = (a >= MBASE) && (off < 16);
        mis  = !valid || ((a % 32'(n)) != 0) || (mmio && n != 4);
        acc  = we && !mis && !ram && !mmio;
        ld   = 0;
        if (busy) begin
            mis = 1'b0;
            acc = 1'b0;
        end else if (!mis) begin
            if (ram) begin
                v = 0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = m_bytes[a + i];
                if (sgn && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                ld = v;
            end else if (mmio) begin
                case (off)
                    0:       ld = cyc;
                    4:       ld = m_store_cnt;
                    8:       ld = m_scratch;
                    default: ld = 0;
                endcase
            end
            if (we) begin
                if (ram) begin
                    for (int i = 0; i < n; i++) m_bytes[a + i] = d[8*i +: 8];
                    m_store_cnt++;
                end else if (mmio && off == 8) begin
                    m_scratch = d;
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        exp_t        e;
        logic [31:0] ld;
        bit          mis, acc;
        @(posedge clk);
        #1;
        bus.WriteEn      = we;
        bus.MemAddress   = a;
        bus.MemStoreData = d;
        bus.Funct3       = f3;
        e.busy = (cyc < DEPTH);
        model_step(we, a, d, f3, ld, mis, acc);
        e.ld  = ld;
        e.mis = prev_mis;
        e.acc = prev_acc;
        sb_q.push_back(e);
        prev_mis = mis;
        prev_acc = acc;
    endtask

    task automatic idle();
        issue(1'b0, 32'h8000_0000, 32'h0, F_W);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(bus.Busy), 32'd1);
        check("rst_misalign", 32'(bus.MisalignErr), 32'd0);
        check("rst_accesserr", 32'(bus.AccessErr), 32'd0);
        check("rst_loaddata", bus.MemLoadData, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        check("pre_reset_misalign", 32'(bus.MisalignErr), 32'(prev_mis));
        check("pre_reset_accesserr", 32'(bus.AccessErr), 32'(prev_acc));
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_clear();
        int guard = 0;
        while (cyc < DEPTH && guard < 4*DEPTH) begin
            if (cyc == 5) issue(1'b1, 32'h40, 32'hDEAD_BEEF, F_W);
            else          idle();
            guard++;
        end
        checks++;
        if (guard >= 4*DEPTH) begin
            errors++;
            $display("FAIL clear_timeout: got %0d cycles expected under %0d", guard, 4*DEPTH);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(4*i), 32'h0, F_W);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("load_data", bus.MemLoadData, e.ld);
                check("busy", 32'(bus.Busy), 32'(e.busy));
                check("misalign_err", 32'(bus.MisalignErr), 32'(e.mis));
                check("access_err", 32'(bus.AccessErr), 32'(e.acc));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        logic [2:0]  f3;
        int          sel;
        rst_n            = 1'b0;
        bus.WriteEn      = 1'b0;
        bus.MemAddress   = 32'h8000_0000;
        bus.MemStoreData = 32'h0;
        bus.Funct3       = F_W;
        model_reset();
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_clear();
        for (int i = 0; i < 20; i++) issue(1'b0, 32'(4*i), 32'h0, F_W);

        // Sub-word merge and load extension
        issue(1'b1, 32'h10, 32'h1122_3344, F_W);
        issue(1'b1, 32'h13, 32'h0000_00AA, F_B);
        issue(1'b1, 32'h10, 32'h0000_BEEF, F_H);
        issue(1'b0, 32'h10, 32'h0, F_W);
        issue(1'b0, 32'h13, 32'h0, F_B);
        issue(1'b0, 32'h13, 32'h0, F_BU);
        issue(1'b0, 32'h10, 32'h0, F_H);
        issue(1'b0, 32'h12, 32'h0, F_HU);

        // Misalignment and invalid size
        issue(1'b1, 32'h20, 32'h5566_7788, F_W);
        issue(1'b1, 32'h22, 32'h1234_5678, F_W);
        issue(1'b0, 32'h21, 32'h0, F_H);
        issue(1'b0, 32'h20, 32'h0, F_W);
        issue(1'b0, 32'h20, 32'h0, 3'b111);
        issue(1'b1, 32'h24, 32'h9, 3'b011);
        idle();
        issue(1'b0, 32'h24, 32'h0, F_W);

        // Unmapped
        issue(1'b1, 32'(4*DEPTH), 32'hFFFF_FFFF, F_W);
        issue(1'b0, 32'(4*DEPTH), 32'h0, F_W);
        idle();
        issue(1'b0, 32'h0, 32'h0, F_W);
        issue(1'b1, 32'h1234_5679, 32'h1, F_H);
        idle();

        // Status window
        issue(1'b0, MBASE + 4, 32'h0, F_W);
        issue(1'b1, MBASE + 8, 32'hCAFE_F00D, F_W);
        issue(1'b0, MBASE + 8, 32'h0, F_W);
        issue(1'b0, MBASE, 32'h0, F_W);
        repeat (7) idle();
        issue(1'b0, MBASE, 32'h0, F_W);
        issue(1'b1, MBASE + 8, 32'h77, F_B);
        issue(1'b0, MBASE + 8, 32'h0, F_W);
        issue(1'b1, MBASE + 4, 32'h5, F_W);
        issue(1'b1, MBASE, 32'h5, F_W);
        issue(1'b1, MBASE + 12, 32'h5, F_W);
        issue(1'b0, MBASE + 12, 32'h0, F_W);
        issue(1'b0, MBASE + 4, 32'h0, F_W);
        issue(1'b0, MBASE + 2, 32'h0, F_H);
        idle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                a = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            end else if (sel == 7) begin
                a = MBASE + 32'($urandom_range(0, 15));
            end else if (sel == 8) begin
                a = 32'h1000_0000 + 32'($urandom_range(0, 255));
            end else begin
                a = MBASE + 32'(4 * $urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0:       f3 = F_B;
                    1:       f3 = F_H;
                    2:       f3 = F_W;
                    3:       f3 = F_BU;
                    default: f3 = F_HU;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            issue(1'($urandom_range(0, 1)), a, $urandom, f3);
        end
        read_all();

        // Fill, reset after a store, reset mid-clear, then verify full re-clear
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(4*i), $urandom | 32'h1, F_W);
        issue(1'b1, 32'h22, 32'h0, F_W);
        do_reset();
        repeat (40) idle();
        do_reset();
        run_clear();
        read_all();
        issue(1'b0, MBASE, 32'h0, F_W);
        issue(1'b0, MBASE + 4, 32'h0, F_W);
        issue(1'b0, MBASE + 8, 32'h0, F_W);
        idle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
